// File: rtl/mc_apb_pkg.sv
// rtl/mc_apb_pkg.sv - FSM state type and ECC_STATUS field positions for the APB register file
package mc_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } apb_state_e;

  localparam int ECC_SBE_BIT     = 0;
  localparam int ECC_DBE_BIT     = 1;
  localparam int ECC_CNT_LSB     = 8;
  localparam int ECC_CNT_W       = 8;
  localparam int ECC_STATUS_W    = 16;

  localparam int WAIT_STATES_MAX = 7;
  localparam int WAIT_CNT_W      = 3;

endpackage

// File: rtl/mc_ecc_status_reg.sv
// rtl/mc_ecc_status_reg.sv - sticky SBE/DBE flags and saturating SBE counter
// Any clear source wins over a same-cycle error event, which is then dropped.
module mc_ecc_status_reg
  import mc_apb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sw_rst,
  input  logic                    clr,
  input  logic                    w1c_sbe,
  input  logic                    w1c_dbe,
  input  logic                    clr_cnt,
  input  logic                    sbe,
  input  logic                    dbe,
  output logic [ECC_STATUS_W-1:0] status
);

  logic                 sbe_q;
  logic                 dbe_q;
  logic [ECC_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn || sw_rst) begin
      sbe_q <= 1'b0;
      dbe_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (clr || w1c_sbe)    sbe_q <= 1'b0;
      else if (sbe)          sbe_q <= 1'b1;

      if (clr || w1c_dbe)    dbe_q <= 1'b0;
      else if (dbe)          dbe_q <= 1'b1;

      if (clr || clr_cnt)             cnt_q <= '0;
      else if (sbe && (cnt_q != '1))  cnt_q <= cnt_q + ECC_CNT_W'(1);
    end
  end

  always_comb begin
    status                          = '0;
    status[ECC_SBE_BIT]             = sbe_q;
    status[ECC_DBE_BIT]             = dbe_q;
    status[ECC_CNT_LSB +: ECC_CNT_W] = cnt_q;
  end

endmodule

// File: rtl/mc_apb_regfile.sv
// rtl/mc_apb_regfile.sv - APB slave with byte-strobed control registers and a top ECC_STATUS register
// Transfer attributes are captured on entry to SETUP; responses are registered and last one cycle.
module mc_apb_regfile
  import mc_apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                            zmc_top_clk,
  input  logic                            zmc_top_rstn,
  input  logic                            zmc_top_sw_rst,
  input  logic                            i_psel,
  input  logic                            i_penable,
  input  logic                            i_pwrite,
  input  logic [ADDR_W-1:0]               i_paddr,
  input  logic [DATA_W-1:0]               i_pwdata,
  input  logic [DATA_W/8-1:0]             i_pstrb,
  input  logic                            i_ECC_STAUS_REG_clear,
  input  logic                            i_ecc_sbe,
  input  logic                            i_ecc_dbe,
  output logic [DATA_W-1:0]               o_prdata,
  output logic                            o_pready,
  output logic                            o_pslverr,
  output logic [(NUM_REGS-1)*DATA_W-1:0]  o_ctrl_regs
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int OFF_W   = $clog2(STRB_W);
  localparam int ECC_IDX = NUM_REGS - 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
    WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  apb_state_e              state_q;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    write_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [STRB_W-1:0]       strb_q;
  logic [DATA_W-1:0]       ctrl_q [NUM_REGS-1];

  logic                    rst;
  logic                    setup_req;
  logic                    enter_access;
  logic [ADDR_W-1:0]       idx;
  logic                    addr_err;
  logic [DATA_W-1:0]       rd_val;
  logic                    wr_fire;
  logic                    ecc_wr;
  logic [ECC_STATUS_W-1:0] ecc_status;

  assign rst          = !zmc_top_rstn || zmc_top_sw_rst;
  assign setup_req    = i_psel && !i_penable;
  assign enter_access = i_psel &&
                        (((state_q == ST_SETUP) && (WAIT_STATES == 0)) ||
                         ((state_q == ST_WAIT) && (wait_cnt_q == WAIT_LAST)));
  assign idx          = addr_q >> OFF_W;
  assign addr_err     = (idx >= ADDR_W'(NUM_REGS)) || (addr_q[OFF_W-1:0] != '0);
  assign wr_fire      = (state_q == ST_ACCESS) && write_q && !addr_err;
  assign ecc_wr       = wr_fire && (idx == ADDR_W'(ECC_IDX));

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (idx == ADDR_W'(i)) rd_val = ctrl_q[i];
    end
    if (idx == ADDR_W'(ECC_IDX)) rd_val = DATA_W'(ecc_status);
  end

  always_ff @(posedge zmc_top_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      o_prdata   <= '0;
      o_pready   <= 1'b0;
      o_pslverr  <= 1'b0;
    end else begin
      o_prdata  <= '0;
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ACCESS: begin
          if (setup_req) begin
            state_q <= ST_SETUP;
            addr_q  <= i_paddr;
            write_q <= i_pwrite;
            wdata_q <= i_pwdata;
            strb_q  <= i_pstrb;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          wait_cnt_q <= '0;
          if (!i_psel)              state_q <= ST_IDLE;
          else if (WAIT_STATES > 0) state_q <= ST_WAIT;
          else                      state_q <= ST_ACCESS;
        end
        ST_WAIT: begin
          if (!i_psel) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q    <= ST_ACCESS;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Response is prepared on the edge into ACCESS so it is visible for that whole cycle.
      if (enter_access) begin
        o_pready  <= 1'b1;
        o_pslverr <= addr_err;
        o_prdata  <= (!write_q && !addr_err) ? rd_val : '0;
      end
    end
  end

  always_ff @(posedge zmc_top_clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS - 1; r++) ctrl_q[r] <= '0;
    end else if (wr_fire) begin
      for (int r = 0; r < NUM_REGS - 1; r++) begin
        if (idx == ADDR_W'(r)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (strb_q[b]) ctrl_q[r][b*8 +: 8] <= wdata_q[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_flat
    assign o_ctrl_regs[g*DATA_W +: DATA_W] = ctrl_q[g];
  end

  mc_ecc_status_reg u_ecc_status (
    .clk     (zmc_top_clk),
    .rstn    (zmc_top_rstn),
    .sw_rst  (zmc_top_sw_rst),
    .clr     (i_ECC_STAUS_REG_clear),
    .w1c_sbe (ecc_wr && strb_q[0] && wdata_q[ECC_SBE_BIT]),
    .w1c_dbe (ecc_wr && strb_q[0] && wdata_q[ECC_DBE_BIT]),
    .clr_cnt (ecc_wr && strb_q[1] && wdata_q[ECC_CNT_LSB]),
    .sbe     (i_ecc_sbe),
    .dbe     (i_ecc_dbe),
    .status  (ecc_status)
  );

endmodule
